// File: rtl/decoder_pkg.sv
// ============================================================
// decoder_pkg : shared mode and FSM encodings for decoder_seq
// Rev 1.0
// ============================================================
`default_nettype none

package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERMO = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/decoder_core.sv
// ============================================================
// decoder_core : combinational code/mode -> OUT_W pattern
// Rev 1.0
// ============================================================
`default_nettype none

module decoder_core
  import decoder_pkg::*;
#(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]      code_i,
  input  mode_e                mode_i,
  output logic [(2**IN_W)-1:0] pattern_o
);

  localparam int OUT_W = 2**IN_W;

  always_comb begin
    pattern_o = '0;
    unique case (mode_i)
      MODE_ONEHOT, MODE_SCAN: pattern_o[code_i] = 1'b1;
      MODE_THERMO: begin
        for (int i = 0; i < OUT_W; i++) begin
          pattern_o[i] = (IN_W'(i) <= code_i);
        end
      end
      default: pattern_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/decoder_seq.sv
// ============================================================
// decoder_seq : registered binary decoder with one-hot,
//               thermometer and multi-beat scan modes
// Rev 1.0
// ============================================================
`default_nettype none

module decoder_seq
  import decoder_pkg::*;
#(
  parameter int IN_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_code,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**IN_W)-1:0]  out_data,
  output logic                  out_last,
  output logic                  err
);

  localparam int OUT_W = 2**IN_W;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   cnt_q, cnt_d;
  logic [IN_W-1:0]   tgt_q, tgt_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              err_q, err_d;

  mode_e             req_mode;
  logic              final_pending;
  logic              accept;
  logic              take;
  logic              scan_multi;
  logic [IN_W-1:0]   cnt_inc;
  logic [IN_W-1:0]   core_code;
  mode_e             core_mode;
  logic [OUT_W-1:0]  core_pat;

  assign req_mode = mode_e'(in_mode);
  assign cnt_inc  = cnt_q + IN_W'(1);

  // The final scan beat counts as "idle" so a new request can ride its hand-off.
  assign final_pending = (state_q == ST_IDLE) || (cnt_q == tgt_q);
  assign in_ready      = !rst && final_pending && (!out_valid_q || out_ready);

  assign accept     = in_valid && in_ready;
  assign take       = out_valid_q && out_ready;
  assign scan_multi = (req_mode == MODE_SCAN) && (in_code != '0);

  // Single core shared between new requests and subsequent scan beats.
  assign core_code = accept ? ((req_mode == MODE_SCAN) ? '0 : in_code) : cnt_inc;
  assign core_mode = accept ? req_mode : MODE_SCAN;

  decoder_core #(
    .IN_W (IN_W)
  ) u_core (
    .code_i    (core_code),
    .mode_i    (core_mode),
    .pattern_o (core_pat)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = core_pat;
      out_last_d  = !scan_multi;
      err_d       = (req_mode == MODE_RSVD);
      cnt_d       = '0;
      tgt_d       = scan_multi ? in_code : '0;
      state_d     = scan_multi ? ST_SCAN : ST_IDLE;
    end else if (take) begin
      if ((state_q == ST_SCAN) && (cnt_q != tgt_q)) begin
        cnt_d      = cnt_inc;
        out_data_d = core_pat;
        out_last_d = (cnt_inc == tgt_q);
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_last_d  = 1'b0;
        cnt_d       = '0;
        tgt_d       = '0;
        state_d     = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tgt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder_seq.sv
// ============================================================
// tb_decoder_seq : scoreboard bench for decoder_seq (IN_W=3 and IN_W=10)
// Rev 1.0
// ============================================================
`default_nettype none

module tb_decoder_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_code;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        err;

  logic          t_in_valid;
  logic          t_in_ready;
  logic [9:0]    t_in_code;
  logic [1:0]    t_in_mode;
  logic          t_out_valid;
  logic          t_out_ready;
  logic [1023:0] t_out_data;
  logic          t_out_last;
  logic          t_err;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic acc_ov, acc_ol;

  decoder_seq #(.IN_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .err       (err)
  );

  decoder_seq #(.IN_W(10)) dut10 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (t_in_valid),
    .in_ready  (t_in_ready),
    .in_code   (t_in_code),
    .in_mode   (t_in_mode),
    .out_valid (t_out_valid),
    .out_ready (t_out_ready),
    .out_data  (t_out_data),
    .out_last  (t_out_last),
    .err       (t_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l, input logic e);
    exp_t x;
    x.data = d;
    x.last = l;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic send(input logic [2:0] code, input logic [1:0] mode);
    bit ok;
    ok       = 1'b0;
    in_code  = code;
    in_mode  = mode;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      #1;
      if (in_ready) begin
        ok     = 1'b1;
        acc_ov = out_valid;
        acc_ol = out_last;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: samples after stimulus settles, well before the next rising edge.
  logic       prev_valid, prev_take, prev_last;
  logic [7:0] prev_data;
  initial begin
    prev_valid = 1'b0;
    prev_take  = 1'b0;
    prev_last  = 1'b0;
    prev_data  = '0;
  end

  always begin
    logic take, first;
    exp_t e;
    @(negedge clk);
    #3;
    if (rst) begin
      prev_valid = 1'b0;
      prev_take  = 1'b0;
    end else begin
      take  = out_valid && out_ready;
      first = out_valid && (!prev_valid || prev_take);
      if (prev_valid && !prev_take) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(prev_data));
        chk("hold_last", 64'(out_last), 64'(prev_last));
      end
      if (first) begin
        if (sb.size() == 0) chk("unexpected_beat", 64'(out_data), 64'hDEAD);
        else chk("err_on_first", 64'(err), 64'(sb[0].err));
      end else if (err) begin
        chk("err_stray", 64'(err), 64'd0);
      end
      if (take && sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat_data", 64'(out_data), 64'(e.data));
        chk("beat_last", 64'(out_last), 64'(e.last));
      end
      prev_valid = out_valid;
      prev_take  = take;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [1023:0] exp10;
    bit ok10;
    rst = 1'b1;  in_valid = 1'b0;  in_code = '0;  in_mode = '0;  out_ready = 1'b1;
    t_in_valid = 1'b0;  t_in_code = '0;  t_in_mode = '0;  t_out_ready = 1'b1;
    acc_ov = 1'b0;  acc_ol = 1'b0;

    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_err",       64'(err),       64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // One-hot and thermometer single beats
    push(8'h20, 1'b1, 1'b0);  send(3'd5, 2'b00);  drain();
    push(8'h07, 1'b1, 1'b0);  send(3'd2, 2'b01);
    push(8'hFF, 1'b1, 1'b0);  send(3'd7, 2'b01);  drain();

    // Scan of code 3 with a 3-cycle stall on beat 1
    push(8'h01, 1'b0, 1'b0);  push(8'h02, 1'b0, 1'b0);
    push(8'h04, 1'b0, 1'b0);  push(8'h08, 1'b1, 1'b0);
    send(3'd3, 2'b10);
    chk("scan_ready_b0", 64'(in_ready), 64'd0);
    tick();
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_ready", 64'(in_ready), 64'd0);
      chk("stall_data",  64'(out_data), 64'h02);
    end
    out_ready = 1'b1;
    drain();

    // Full-length scan followed back-to-back by a one-hot request
    for (int k = 0; k < 8; k++) push(8'(1 << k), (k == 7), 1'b0);
    push(8'h01, 1'b1, 1'b0);
    send(3'd7, 2'b10);
    send(3'd0, 2'b00);
    chk("b2b_accept_on_final", 64'({acc_ov, acc_ol}), 64'd3);
    chk("b2b_no_bubble", 64'(out_valid), 64'd1);
    drain();

    // Scan of code 0 is a single beat
    push(8'h01, 1'b1, 1'b0);  send(3'd0, 2'b10);
    chk("scan0_ready", 64'(in_ready), 64'd1);
    drain();

    // Reserved mode: immediate take, then a stalled take
    push(8'h00, 1'b1, 1'b1);  send(3'd4, 2'b11);  drain();
    push(8'h00, 1'b1, 1'b1);
    out_ready = 1'b0;
    send(3'd4, 2'b11);
    tick();
    out_ready = 1'b1;
    drain();

    // Reset during beat 2 of scan code 6
    push(8'h01, 1'b0, 1'b0);  push(8'h02, 1'b0, 1'b0);
    send(3'd6, 2'b10);
    tick();
    tick();
    chk("pre_rst_beat2", 64'(out_data), 64'h04);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data",  64'(out_data),  64'd0);
    chk("midrst_out_last",  64'(out_last),  64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd0);
    chk("midrst_queue",     64'(sb.size()), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("post_rst_idle", 64'(out_valid), 64'd0);

    // IN_W=10 one-hot of the top code
    exp10 = '0;
    exp10[1023] = 1'b1;
    t_in_code  = 10'd1023;
    t_in_mode  = 2'b00;
    t_in_valid = 1'b1;
    ok10 = 1'b0;
    for (int i = 0; i < 20 && !ok10; i++) begin
      #1;
      if (t_in_ready) ok10 = 1'b1;
      tick();
    end
    t_in_valid = 1'b0;
    chk("w10_accept", 64'(ok10), 64'd1);
    chk("w10_valid", 64'(t_out_valid), 64'd1);
    chk("w10_last",  64'(t_out_last),  64'd1);
    n_cmp++;
    if (t_out_data !== exp10) begin
      n_fail++;
      $display("FAIL w10_data: got popcount %0d bit1023=%0b, expected only bit 1023 set",
               $countones(t_out_data), t_out_data[1023]);
    end
    tick();
    chk("w10_one_beat", 64'(t_out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 Parameter IN_W, default 3, SHALL set binary code width (legal range 1..10).
REQ-002 Derived constant OUT_W SHALL equal 2**IN_W; it SHALL NOT be overridable.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL flag a request present on in_code/in_mode.
REQ-006 in_ready  output  1  SHALL flag that the block accepts a request this cycle.
REQ-007 in_code  input  IN_W  SHALL be the binary code to decode.
REQ-008 in_mode  input  2  SHALL select decode mode: 00 one-hot, 01 thermometer, 10 scan, 11 reserved.
REQ-009 out_valid  output  1  SHALL flag a valid beat on out_data/out_last.
REQ-010 out_ready  input  1  SHALL flag that the consumer takes the current beat.
REQ-011 out_data  output  OUT_W  SHALL carry the decoded pattern.
REQ-012 out_last  output  1  SHALL mark the final beat of a request.
REQ-013 err  output  1  SHALL pulse for one cycle when a reserved-mode request is accepted.

Function
REQ-014 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_code/in_mode SHALL be captured at that edge.
REQ-015 in_ready SHALL be 1 only when FSM is IDLE and (out_valid=0 or out_ready=1); it SHALL NOT depend combinationally on in_valid.
REQ-016 Latency SHALL be one cycle: first beat's out_valid asserts the cycle after accept.
REQ-017 One-hot mode SHALL emit one beat: out_data = 1 << in_code, out_last=1.
REQ-018 Thermometer mode SHALL emit one beat: out_data bits [in_code:0] set, all others 0, out_last=1.
REQ-019 Scan mode SHALL emit in_code+1 beats; beat k (k=0..in_code) carries out_data = 1 << k; out_last=1 only on beat k=in_code.
REQ-020 Reserved mode SHALL emit one beat with out_data=0, out_last=1, and err=1 in the same cycle out_valid rises.
REQ-021 FSM states SHALL be IDLE and SCAN; IDLE->SCAN on accept of a scan request with in_code>0; SCAN->IDLE when beat k=in_code is taken (out_valid & out_ready); all other requests stay in IDLE.
REQ-022 Scan with in_code=0 SHALL produce a single beat 0x..01 with out_last=1 and SHALL NOT enter SCAN.
REQ-023 Scan beat counter SHALL be IN_W bits; in_code=OUT_W-1 SHALL yield exactly OUT_W beats with no wrap or extra beat.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL hold stable.
REQ-025 When final beat is taken and in_valid=1 in the same cycle, the new request SHALL be accepted that cycle, giving back-to-back beats with no bubble.
REQ-026 out_valid SHALL deassert the cycle after the final beat is taken if no new request was accepted.
REQ-027 Output pattern generation SHALL be fully registered; no combinational path from in_* to out_*.

Reset
REQ-028 While rst=1: out_valid=0, out_data=0, out_last=0, err=0, in_ready=0, FSM=IDLE, counter=0.
REQ-029 in_ready SHALL be 1 in the first clock cycle after rst deasserts.
REQ-030 rst asserted mid-scan SHALL abort immediately; no remaining beats SHALL be emitted after deassertion.

Structure
REQ-031 Package decoder_pkg SHALL hold the mode encoding enum (ONEHOT, THERMO, SCAN, RSVD) and the FSM state enum.
REQ-032 Combinational pattern generation SHALL live in one sub-module decoder_core (code, mode -> OUT_W pattern), instantiated once.

Verification (IN_W=3 unless stated)
REQ-033 Reset release, in_code=5 mode 00, out_ready=1 -> next cycle out_data=0x20, out_last=1, out_valid for one cycle.
REQ-034 in_code=2 mode 01 -> out_data=0x07, out_last=1; in_code=7 mode 01 -> 0xFF.
REQ-035 in_code=3 mode 10, out_ready held 0 for 3 cycles on beat 1 -> beats 0x01,0x02(held stable),0x04,0x08; out_last only on 0x08; in_ready=0 throughout.
REQ-036 in_code=7 mode 10 then one-hot code 0 presented during last beat -> 8 scan beats then 0x01 on next cycle, no bubble.
REQ-037 mode 11 code 4 -> out_data=0x00, out_last=1, err=1 for exactly one cycle.
REQ-038 rst pulsed during beat 2 of scan code 6 -> all outputs 0 in reset; no beats after release; IN_W=10 run of one-hot code 1023 -> out_data bit 1023 only.
